// File: rtl/pc_pkg.sv
// pc_pkg: shared next-PC source encoding, default vectors and alignment for pc_unit.
package pc_pkg;

    typedef enum logic [2:0] {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR, PC_EXC} pc_src_e;

    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VECTOR   = 32'h8000_0180;
    localparam int          INSTR_ALIGN     = 2;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with saturating count and registered mispredict flag.
module pc_ras #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic [WIDTH-1:0] ret_target,
    output logic [WIDTH-1:0] top,
    output logic             valid,
    output logic             mispredict
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptr_inc;
    logic [PW:0]      count;

    assign ptr_inc = ptr + 1'b1;
    assign valid   = count != '0;
    assign top     = valid ? mem[ptr] : '0;

    // ptr always indexes the top entry; pushing past full wraps onto the oldest
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ptr        <= '0;
            count      <= '0;
            mispredict <= 1'b0;
        end else begin
            mispredict <= pop && (!valid || ret_target != top);
            if (push && pop)
                count <= valid ? count : (PW+1)'(1);
            else if (push) begin
                ptr   <= ptr_inc;
                count <= count == (PW+1)'(DEPTH) ? count : count + 1'b1;
            end else if (pop && valid) begin
                ptr   <= ptr - 1'b1;
                count <= count - 1'b1;
            end
        end

    always_ff @(posedge clk)
        if (push && pop)
            mem[ptr] <= push_data;
        else if (push)
            mem[ptr_inc] <= push_data;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with internal next-PC selection, EPC capture and jr misalign trap.
// Define PC_RAS_EN to build the return-address stack (call/ret tracking and ras_mispredict).
module pc_unit
    import pc_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(PC_EXC_VECTOR),
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jump,
    input  logic [25:0]      jump_idx,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_target,
    input  logic             exc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] epc,
    output logic             trap_misalign,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_valid,
    output logic             ras_mispredict
);

    pc_src_e          src;
    logic             misalign;
    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] jmp_target;
    logic [WIDTH-1:0] pc_next;

    assign pc_plus4   = pc + WIDTH'(4);
    assign br_target  = pc_plus4 + {{(WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
    // masking keeps the region bits correct even at the minimum WIDTH of 28
    assign jmp_target = (pc_plus4 & ~WIDTH'(28'hFFF_FFFF)) | WIDTH'({jump_idx, 2'b00});
    assign misalign   = jr && jr_target[INSTR_ALIGN-1:0] != '0;

    always_comb begin
        src     = exc || misalign ? PC_EXC : jr ? PC_JR : jump ? PC_JUMP : branch_taken ? PC_BRANCH : PC_SEQ;
        pc_next = src == PC_EXC ? EXC_VECTOR : src == PC_JR ? jr_target : src == PC_JUMP ? jmp_target :
                  src == PC_BRANCH ? br_target : pc_plus4;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pc            <= RESET_VECTOR;
            epc           <= '0;
            trap_misalign <= 1'b0;
        end else begin
            trap_misalign <= src == PC_EXC && !exc && !stall;
            if (exc || !stall) begin
                pc <= pc_next;
                if (src == PC_EXC)
                    epc <= pc;
            end
        end

`ifdef PC_RAS_EN
    logic ras_upd;

    assign ras_upd = !stall && (src == PC_JUMP || src == PC_JR);

    pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
        .clk        (clk),
        .rst        (rst),
        .push       (ras_upd && call),
        .pop        (ras_upd && ret),
        .push_data  (pc_plus4),
        .ret_target (jr_target),
        .top        (ras_top),
        .valid      (ras_valid),
        .mispredict (ras_mispredict)
    );
`else
    logic unused_ras;

    assign unused_ras     = ^{call, ret, RAS_DEPTH[0]};
    assign ras_top        = '0;
    assign ras_valid      = 1'b0;
    assign ras_mispredict = 1'b0;
`endif

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS core, and the successor to the plain PC register. Holds the fetch address and computes the next PC internally: sequential, branch, jump, jump-register or exception vector. Adds stall, an EPC capture register, jump-register misalignment trapping and an optional return-address stack (RAS) for call/return prediction statistics. Sits between the control/ALU decode outputs and instruction memory.

## Interface
- WIDTH, 32: address width; must be ≥ 28.
- RESET_VECTOR, 32'h0000_0000: PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180: target on exception or misaligned jr.
- RAS_DEPTH, 4: RAS entries; power of two, ≥ 2.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- stall  in  1  hold PC, EPC and RAS
- branch_taken  in  1  take the conditional branch
- branch_imm  in  16  raw branch immediate
- jump  in  1  j/jal
- jump_idx  in  26  jump instruction index
- jr  in  1  jr/jalr
- jr_target  in  WIDTH  register-sourced target
- exc  in  1  external exception request
- call  in  1  jal/jalr marker (RAS push)
- ret  in  1  `jr $ra` marker (RAS pop)
- pc  out  WIDTH  current fetch address
- pc_plus4  out  WIDTH  pc + 4 (combinational)
- epc  out  WIDTH  PC of the trapping instruction
- trap_misalign  out  1  registered; high for one cycle after a misaligned jr
- ras_top  out  WIDTH  RAS prediction (0 when empty)
- ras_valid  out  1  RAS non-empty
- ras_mispredict  out  1  registered; high for one cycle after ret with target ≠ ras_top or with an empty RAS

## Operation
- Reset (async, any time): pc = RESET_VECTOR, epc = 0, trap_misalign = 0, ras_mispredict = 0, RAS count = 0, ras_top = 0, ras_valid = 0.
- Arithmetic: all results are modulo 2^WIDTH.
  - pc_plus4 = pc + 4.
  - Branch target = pc_plus4 + (sign-extended branch_imm << 2).
  - Jump target = {pc_plus4[WIDTH-1:28], jump_idx, 2'b00}.
- Next-PC priority, highest first:
  1. exc → EXC_VECTOR; epc ← pc.
  2. jr with jr_target[1:0] ≠ 0 → EXC_VECTOR; epc ← pc; trap_misalign pulses.
  3. jr → jr_target.
  4. jump → jump target.
  5. branch_taken → branch target.
  6. Otherwise pc_plus4.
- stall: pc, epc and RAS hold, and registered flags clear. exc overrides stall.
- Lower-priority requests in the same cycle are ignored, including their RAS side effects.
- RAS updates only on a non-stalled cycle with no trap, and only when the selected source is jump or jr.
  - call pushes pc_plus4.
  - ret pops, and ras_mispredict pulses if the stack is empty or jr_target ≠ ras_top.
  - Full stack on push: circular overwrite of the oldest entry; count saturates at RAS_DEPTH.
  - Empty stack on pop: count stays 0.
  - call and ret together: top entry is replaced by pc_plus4; count unchanged, or becomes 1 if the stack was empty.

## Timing
- Single-cycle core: pc updates on the rising edge after the request; it is never combinationally modified.
- pc_plus4, ras_top and ras_valid are combinational from registers.
- trap_misalign and ras_mispredict are valid the cycle after the causing edge, for one cycle.
- Latency from request to new pc: 1 clock.

## Configuration
- PC_RAS_EN defined: RAS logic, call/ret handling and ras_mispredict are present.
- PC_RAS_EN undefined: no RAS storage is built; ras_top = 0, ras_valid = 0, ras_mispredict = 0; call and ret are ignored. Next-PC behaviour is identical in both builds.

## Structure
- Package pc_pkg holds:
  - enum pc_src_e {PC_SEQ, PC_BRANCH, PC_JUMP, PC_JR, PC_EXC}
  - default RESET_VECTOR and EXC_VECTOR constants
  - instruction-word alignment constant (2)
- Sub-module pc_ras (push/pop/replace, circular pointer, saturating count) is instantiated under PC_RAS_EN.

## Test plan
- Reset mid-run with pc = 32'h0000_0040 → pc = 0 immediately; after 3 idle clocks pc = 32'h0000_000C.
- pc = 32'h100, branch_taken, branch_imm = 16'hFFFF → next pc = 32'h100; with stall held the same cycle, pc stays 32'h100 and branch is ignored.
- pc = 32'hF000_0010, jump, jump_idx = 26'h000_0040 → pc = 32'hF000_0100; jr with jr_target = 32'h0000_2000 in the same cycle wins → pc = 32'h2000.
- jr with jr_target = 32'h0000_2002 at pc = 32'h80 → pc = 32'h8000_0180, epc = 32'h80, trap_misalign pulses once; exc asserted together with stall → still vectors.
- PC_RAS_EN, RAS_DEPTH = 4:
  - 5 calls pushing 32'h4, 32'h8, 32'hC, 32'h10, 32'h14 → ras_top = 32'h14, count 4.
  - 4 rets with matching targets → no mispredict.
  - A 5th ret → ras_mispredict pulses.
  - After the 5 calls, the oldest entry (32'h4) has been overwritten.
- call and ret in the same cycle with top = 32'h40 and pc_plus4 = 32'h84 → ras_top = 32'h84, count unchanged.
